vga_tile_scan: RTL and testbench
================================

# vga_tile_scan

Parametrised VGA raster generator with tiled framebuffer fetch. It sits between the CPU data memory and the board VGA pins. It generates configurable horizontal and vertical sync timing and walks a byte-per-tile framebuffer with incremental address counters, so it needs no dividers. It drives 8-bit RGB332 output that is blanked outside the visible area, aligned to sync through a fixed 2-cycle pipeline, and has a built-in test-pattern mode.

## Interface
Parameters:
- H_VIS, 800: visible pixels per line
- H_FP, 56: horizontal front porch (clocks)
- H_SYNC, 120: horizontal sync width
- H_BP, 64: horizontal back porch; H_TOTAL = sum = 1040
- V_VIS, 600: visible lines
- V_FP, 37: vertical front porch (lines)
- V_SYNC, 6: vertical sync width (lines)
- V_BP, 23: vertical back porch; V_TOTAL = sum = 666
- SYNC_ACT_LOW, 1: 1 = Hsync/Vsync low while active
- TILE_W, 32: pixels per tile horizontally
- TILE_H, 32: lines per tile vertically
- STRIDE, 25: framebuffer bytes per tile row
- BASE_ADDR, 32'h400: byte address of tile (0,0)

Ports:
- clk50, in, 1: pixel clock
- rst, in, 1: asynchronous, active-high reset
- pattern_en, in, 1: 1 = output test pattern instead of framebuffer data
- raddr, out, 32: framebuffer byte address
- rdata, in, 32: word containing raddr; valid one clk50 cycle after raddr (synchronous RAM)
- Hsync, out, 1: horizontal sync
- Vsync, out, 1: vertical sync
- red_out, out, 3: red
- green_out, out, 3: green
- blue_out, out, 2: blue
- frame_start, out, 1: one-cycle pulse coincident with pixel (0,0) at pins
- vblank, out, 1: high while pin-stage line is ≥ V_VIS

## Operation
- Stage 0 counters:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps, counts 0..V_TOTAL-1 and wraps to 0.
- visible = (hcnt < H_VIS) && (vcnt < V_VIS).
- Tile walk counters, updated only on visible pixels:
  - tx_px counts 0..TILE_W-1; on wrap, tile_col increments.
  - tx_px and tile_col clear when hcnt wraps.
  - ty_px increments once per line when hcnt wraps and vcnt < V_VIS; on reaching TILE_H it wraps and row_base += STRIDE.
  - All walk counters clear when vcnt wraps.
- raddr = BASE_ADDR + row_base + tile_col, 32-bit modular, from registers only (no combinational path from inputs).
- Byte select: raddr[1:0] delayed 1 cycle picks rdata byte 0..3 (0 = bits 7:0).
- Colour mapping: {red_out, green_out, blue_out} = byte[7:5], byte[4:2], byte[1:0].
- pattern_en = 1: byte = hcnt[7:0] ^ vcnt[7:0] (stage-0 values, pipelined alongside); raddr still advances.
- Blanking: colour outputs are 8'h00 whenever the pin-stage pixel is not visible.
- Sync, before polarity is applied:
  - H active for hcnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC).
  - V active for vcnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC).
  - Pin level = active XOR SYNC_ACT_LOW inverted, i.e. low while active when SYNC_ACT_LOW = 1.

## Timing
- Pipeline stages:
  - Stage 0: counters and raddr.
  - Stage 1: rdata valid; visible, sync, byte select and pattern are registered.
  - Stage 2: all pin outputs registered.
- Latency: every output reflects the stage-0 (hcnt, vcnt) of exactly 2 cycles earlier. Sync, colour, frame_start and vblank stay mutually aligned.
- Reset values, asynchronous and immediate:
  - hcnt, vcnt and all walk counters = 0; raddr = BASE_ADDR.
  - Hsync and Vsync at inactive level (1 for SYNC_ACT_LOW = 1).
  - Colour outputs = 0; frame_start = 0; vblank = 0.
  - Pipeline valid flags = 0.
- After rst deasserts:
  - Stage 0 holds (0,0) on the first edge.
  - frame_start pulses 2 cycles later.
  - Pins carry no stale pipeline data: outputs stay at reset values until valid flags fill.
- Reset mid-frame aborts the frame; scanning restarts at (0,0) and the full frame is regenerated.
- Simultaneous hcnt and vcnt wrap on the last pixel of the frame: the walk counters clear (frame clear takes priority over row_base += STRIDE).
- Non-integral tiling (H_VIS % TILE_W ≠ 0): the last partial tile is fetched normally, and tile_col clears at line wrap.
- pattern_en is sampled at stage 0. A change takes effect on the pixel reaching the pins 2 cycles later, with no glitch on sync.

## Test plan
- Sync timing, defaults, pattern_en = 0:
  - Hsync period is 1040 clocks, low for 120 clocks, and falls 856 clocks after the first visible pixel at the pins.
  - Vsync period is 692640 clocks, low for 6 lines beginning at line 637.
- Address walk: at pixel (x = 33, y = 65), raddr = 0x433. Bench RAM returns 0xAABBCCDD one cycle later, so pins show red = 5, green = 2, blue = 2 two cycles after that pixel's stage 0.
- Blanking: RAM returns 0xFFFFFFFF everywhere → colour = 0 for x ≥ 800 and y ≥ 600; vblank = 1 exactly for lines 600..665.
- Pattern mode: pattern_en = 1, pixel (3,5) → byte 0x06 → red = 0, green = 1, blue = 2.
- Reset mid-frame: assert rst at line 300, pixel 400 → all outputs reach reset values immediately. Release it → frame_start fires 2 cycles after the first edge, and raddr = 0x400 at stage 0.
- Parameter sweep with TILE_W = 37, TILE_H = 27, STRIDE = 22, SYNC_ACT_LOW = 0: pixel (74, 54) → raddr = 0x400 + 2·22 + 2 = 0x42E, and Hsync is high while active.

Source files
------------

// File: rtl/vga_tile_scan.sv
// vga_tile_scan: VGA raster timing with tiled byte-per-tile framebuffer fetch and RGB332 output
module vga_tile_scan #(
   parameter int          H_VIS        = 800,
   parameter int          H_FP         = 56,
   parameter int          H_SYNC       = 120,
   parameter int          H_BP         = 64,
   parameter int          V_VIS        = 600,
   parameter int          V_FP         = 37,
   parameter int          V_SYNC       = 6,
   parameter int          V_BP         = 23,
   parameter int          SYNC_ACT_LOW = 1,
   parameter int          TILE_W       = 32,
   parameter int          TILE_H       = 32,
   parameter int          STRIDE       = 25,
   parameter logic [31:0] BASE_ADDR    = 32'h400
) (
   input  logic        clk50,
   input  logic        rst,
   input  logic        pattern_en,
   output logic [31:0] raddr,
   input  logic [31:0] rdata,
   output logic        Hsync,
   output logic        Vsync,
   output logic [2:0]  red_out,
   output logic [2:0]  green_out,
   output logic [1:0]  blue_out,
   output logic        frame_start,
   output logic        vblank
);
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int XW = $clog2(TILE_W + 1);
   localparam int YW = $clog2(TILE_H + 1);
   localparam logic SYNC_IDLE = SYNC_ACT_LOW != 0;

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [XW-1:0] tx_px;
   logic [YW-1:0] ty_px;
   logic [31:0]   tile_col, row_base;
   logic          v0, v1, vis1, hs1, vs1, fs1, vb1, pen1;
   logic [1:0]    sel1;
   logic [7:0]    pat1, pix;
   logic          h_wrap, v_wrap, visible, tx_last, ty_last;

   assign h_wrap  = int'(hcnt) == H_TOTAL - 1;
   assign v_wrap  = h_wrap && int'(vcnt) == V_TOTAL - 1;
   assign visible = int'(hcnt) < H_VIS && int'(vcnt) < V_VIS;
   assign tx_last = int'(tx_px) == TILE_W - 1;
   assign ty_last = int'(ty_px) == TILE_H - 1;
   assign raddr   = BASE_ADDR + row_base + tile_col;
   assign pix     = pen1 ? pat1 : rdata[8*sel1 +: 8];

   // Stage 0: raster counters and tile walk; the first edge after reset only arms v0 so (0,0) is held once
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         v0       <= 1'b0;
         hcnt     <= '0;
         vcnt     <= '0;
         tx_px    <= '0;
         tile_col <= '0;
         ty_px    <= '0;
         row_base <= '0;
      end else if (!v0) begin
         v0 <= 1'b1;
      end else begin
         hcnt <= h_wrap ? '0 : hcnt + 1'b1;
         if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
         if (v_wrap) begin
            tx_px    <= '0;
            tile_col <= '0;
            ty_px    <= '0;
            row_base <= '0;
         end else if (h_wrap) begin
            tx_px    <= '0;
            tile_col <= '0;
            if (int'(vcnt) < V_VIS) begin
               ty_px <= ty_last ? '0 : ty_px + 1'b1;
               if (ty_last) row_base <= row_base + 32'(STRIDE);
            end
         end else if (visible) begin
            tx_px <= tx_last ? '0 : tx_px + 1'b1;
            if (tx_last) tile_col <= tile_col + 32'd1;
         end
      end
   end

   // Stage 1: register everything derived from stage 0 while the RAM word is being read
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         v1   <= 1'b0;
         vis1 <= 1'b0;
         hs1  <= 1'b0;
         vs1  <= 1'b0;
         fs1  <= 1'b0;
         vb1  <= 1'b0;
         pen1 <= 1'b0;
         sel1 <= '0;
         pat1 <= '0;
      end else begin
         v1   <= v0;
         vis1 <= visible;
         hs1  <= int'(hcnt) >= H_VIS + H_FP && int'(hcnt) < H_VIS + H_FP + H_SYNC;
         vs1  <= int'(vcnt) >= V_VIS + V_FP && int'(vcnt) < V_VIS + V_FP + V_SYNC;
         fs1  <= hcnt == '0 && vcnt == '0;
         vb1  <= int'(vcnt) >= V_VIS;
         pen1 <= pattern_en;
         sel1 <= raddr[1:0];
         pat1 <= 8'(hcnt) ^ 8'(vcnt);
      end
   end

   // Stage 2: pin registers, held at reset levels until the pipeline holds valid data
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         Hsync                            <= SYNC_IDLE;
         Vsync                            <= SYNC_IDLE;
         {red_out, green_out, blue_out}   <= 8'h00;
         frame_start                      <= 1'b0;
         vblank                           <= 1'b0;
      end else begin
         Hsync                            <= v1 ? hs1 ^ SYNC_IDLE : SYNC_IDLE;
         Vsync                            <= v1 ? vs1 ^ SYNC_IDLE : SYNC_IDLE;
         {red_out, green_out, blue_out}   <= v1 && vis1 ? pix : 8'h00;
         frame_start                      <= v1 && fs1;
         vblank                           <= v1 && vb1;
      end
   end
endmodule

// File: tb/tb_vga_tile_scan.sv
// tb_vga_tile_scan: scoreboard bench on a scaled raster, plus a second instance for the tile/polarity sweep
module tb_vga_tile_scan;
   localparam int HV = 100, HF = 4, HS = 8, HB = 4, HT = HV + HF + HS + HB;
   localparam int VV = 70, VF = 2, VS = 3, VB = 2, VT = VV + VF + VS + VB;

   typedef struct {
      bit         ok;
      int         x, y;
      logic [7:0] col;
      logic       hs, vs, fs, vb;
   } exp_t;

   logic        clk50 = 0, rst = 1, pattern_en = 0;
   logic [31:0] rdata = 0, raddr, raddr_b;
   logic        Hsync, Vsync, frame_start, vblank;
   logic [2:0]  red_out, green_out, red_b, green_b;
   logic [1:0]  blue_out, blue_b;
   logic        Hsync_b, Vsync_b, fs_b, vb_b;
   bit          ram_mode = 0, ram_req = 0, pat_req = 0;
   int          pidx = 0, errors = 0, checks = 0;
   exp_t        q[$];

   vga_tile_scan #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
      .clk50(clk50), .rst(rst), .pattern_en(pattern_en), .raddr(raddr), .rdata(rdata),
      .Hsync(Hsync), .Vsync(Vsync), .red_out(red_out), .green_out(green_out),
      .blue_out(blue_out), .frame_start(frame_start), .vblank(vblank));

   vga_tile_scan #(.H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT_LOW(0),
                   .TILE_W(37), .TILE_H(27), .STRIDE(22)) dut_b (
      .clk50(clk50), .rst(rst), .pattern_en(1'b0), .raddr(raddr_b), .rdata(32'h0),
      .Hsync(Hsync_b), .Vsync(Vsync_b), .red_out(red_b), .green_out(green_b),
      .blue_out(blue_b), .frame_start(fs_b), .vblank(vb_b));

   always #5 clk50 = ~clk50;

   // synchronous RAM model: word valid one clock after the address
   always @(posedge clk50) rdata <= ram_mode ? 32'hFFFF_FFFF : 32'hAABB_CCDD;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h (pixel index %0d)", tag, got, want, pidx);
      end
   endtask

   function automatic logic [31:0] exp_addr(int x, int y, int tw, int th, int st);
      return 32'h400 + 32'((y / th) * st + x / tw);
   endfunction

   function automatic bit hact(int x);
      return x >= HV + HF && x < HV + HF + HS;
   endfunction

   function automatic bit vact(int y);
      return y >= VV + VF && y < VV + VF + VS;
   endfunction

   task automatic push_idle();
      exp_t e;
      e.ok = 0; e.x = 0; e.y = 0; e.col = 8'h00; e.hs = 1; e.vs = 1; e.fs = 0; e.vb = 0;
      q.push_back(e);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_pins"}, {Hsync, Vsync, frame_start, vblank, red_out, green_out, blue_out}, {4'b1100, 8'h00});
      chk({tag, "_raddr"}, raddr, 32'h400);
      chk({tag, "_sync_b"}, {Hsync_b, Vsync_b}, 2'b00);
   endtask

   task automatic release_rst();
      @(negedge clk50);
      rst = 0;
      q.delete();
      push_idle();
      push_idle();
      pidx = 0;
   endtask

   task automatic cycle();
      exp_t        e, o;
      int          x, y;
      logic [31:0] w, a;
      logic [7:0]  b;
      @(negedge clk50);
      pattern_en = pat_req;
      ram_mode = ram_req;
      x = pidx % HT;
      y = (pidx / HT) % VT;
      a = exp_addr(x, y, 32, 32, 25);
      w = ram_mode ? 32'hFFFF_FFFF : 32'hAABB_CCDD;
      b = pattern_en ? 8'(x ^ y) : 8'(w >> (8 * a[1:0]));
      e.ok = 1; e.x = x; e.y = y;
      e.col = (x < HV && y < VV) ? b : 8'h00;
      e.hs = !hact(x); e.vs = !vact(y);
      e.fs = x == 0 && y == 0;
      e.vb = y >= VV;
      q.push_back(e);
      if (q.size() > 2) begin
         o = q.pop_front();
         chk("pins", {Hsync, Vsync, frame_start, vblank, red_out, green_out, blue_out},
             {o.hs, o.vs, o.fs, o.vb, o.col});
         if (o.ok) chk("sync_b", {Hsync_b, Vsync_b}, {hact(o.x), vact(o.y)});
      end
      if (x < HV && y < VV) chk("raddr", raddr, a);
      if (x == 33 && y == 65) chk("raddr_33_65", raddr, 32'h433);
      if (x == 74 && y == 54) chk("raddr_b_74_54", raddr_b, 32'h42E);
      if (x < HV && y < VV) chk("raddr_b", raddr_b, exp_addr(x, y, 37, 27, 22));
      pidx++;
   endtask

   initial begin
      repeat (3) @(negedge clk50);
      check_idle("reset");
      release_rst();
      repeat (HT * VT) cycle();
      ram_req = 1;
      repeat (HT * VT) cycle();
      ram_req = 0;
      pat_req = 1;
      repeat (HT * 10 + 37) cycle();
      pat_req = 0;
      repeat (HT + 5) cycle();
      pat_req = 1;
      repeat (HT * 3) cycle();
      pat_req = 0;
      while ((pidx - 1) % (HT * VT) != 30 * HT + 40) cycle();
      #1 rst = 1;
      #1 check_idle("mid_reset");
      repeat (4) @(negedge clk50);
      check_idle("held_reset");
      release_rst();
      repeat (HT * VT + 3) cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
